// File: rtl/cdd_host_link_if.sv
// Command/status bus between the CD-block logic and the CDD host link.
// Latency: none (wires only).
// Backpressure: none; cmd_busy tells the CD-block whether its last command is still pending.
//
// Signals:
//   cmd_dat       command frame, byte n at [8n+7:8n]
//   cmd_wr        load cmd_dat into the pending command register
//   cmd_busy      pending command not yet taken by a frame
//   stat_dat      last complete status frame, byte n at [8n+7:8n]
//   stat_vld      1-cycle pulse: stat_dat updated
//   stat_csum_err checksum error flag, valid with stat_vld
//   frame_err     1-cycle pulse: frame aborted (timeout or resync)
//   active        frame in progress
interface cdd_host_link_if;
    logic [95:0] cmd_dat;
    logic        cmd_wr;
    logic        cmd_busy;
    logic [95:0] stat_dat;
    logic        stat_vld;
    logic        stat_csum_err;
    logic        frame_err;
    logic        active;

    // CD-block side
    modport master (
        output cmd_dat, cmd_wr,
        input  cmd_busy, stat_dat, stat_vld, stat_csum_err, frame_err, active
    );

    // Link side
    modport slave (
        input  cmd_dat, cmd_wr,
        output cmd_busy, stat_dat, stat_vld, stat_csum_err, frame_err, active
    );
endinterface

// File: rtl/cdd_host_link.sv
// Host end of the CDD serial command/status link: 12-byte LSB-first command out, status in.
// Latency: first COMCLK fall 1 clk after the synchronised COMREQ_N edge; 16*CLK_DIV clks per byte.
// Backpressure: drive paces bytes via COMREQ_N; a new CMD_WR overwrites the pending command.
//
// Ports:
//   i_clk, i_rst        system clock, synchronous active-high reset
//   io_host             command/status bus (slave modport)
//   o_cd_comclk         serial clock to drive, idle high
//   o_cd_hdata          host->drive data, changes on COMCLK fall
//   i_cd_cdata          drive->host data, sampled at the end of the COMCLK low phase
//   i_cd_comreq_n       drive byte request, falling edge = request
//   i_cd_comsync_n      low = current request is byte 0 of a frame
module cdd_host_link #(
    parameter int CLK_DIV   = 8,
    parameter int TIMEOUT   = 4096,
    parameter bit AUTO_CSUM = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    cdd_host_link_if.slave        io_host,
    output logic                  o_cd_comclk,
    output logic                  o_cd_hdata,
    input  logic                  i_cd_cdata,
    input  logic                  i_cd_comreq_n,
    input  logic                  i_cd_comsync_n
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [95:0]      IDLE_FRAME = {8'hFF, 88'h0};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_WAIT,
        ST_DONE
    } state_t;

    // ~(sum of bytes 0..10), 8-bit wrap
    function automatic logic [7:0] f_csum(input logic [95:0] frame);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 11; i++) begin
            s = s + frame[8*i +: 8];
        end
        return ~s;
    endfunction

    // ------------------------------------------------------------------
    // Input synchronisers and request edge detect
    // ------------------------------------------------------------------
    logic [1:0] r_cdata_s;
    logic [1:0] r_comreq_s;
    logic [1:0] r_comsync_s;
    logic       r_comreq_d;
    logic       w_req;
    logic       w_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cdata_s   <= 2'b00;
            r_comreq_s  <= 2'b11;
            r_comsync_s <= 2'b11;
            r_comreq_d  <= 1'b1;
        end else begin
            r_cdata_s   <= {r_cdata_s[0], i_cd_cdata};
            r_comreq_s  <= {r_comreq_s[0], i_cd_comreq_n};
            r_comsync_s <= {r_comsync_s[0], i_cd_comsync_n};
            r_comreq_d  <= r_comreq_s[1];
        end
    end

    assign w_req  = r_comreq_d & ~r_comreq_s[1];
    assign w_sync = ~r_comsync_s[1];

    // ------------------------------------------------------------------
    // FSM state and bit/byte/phase counters
    // ------------------------------------------------------------------
    state_t           r_state, w_state_nxt;
    logic [3:0]       r_idx, w_idx_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
    logic             w_start;
    logic             w_sample;
    logic             w_frame_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_bit   <= 3'd0;
            r_div   <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_bit   <= w_bit_nxt;
            r_div   <= w_div_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_bit_nxt   = r_bit;
        w_div_nxt   = r_div;
        w_tmo_nxt   = r_tmo;
        w_start     = 1'b0;
        w_sample    = 1'b0;
        w_frame_err = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Only a byte-0 request can open a frame
                if (w_req && w_sync) begin
                    w_start     = 1'b1;
                    w_idx_nxt   = 4'd0;
                    w_bit_nxt   = 3'd0;
                    w_div_nxt   = '0;
                    w_state_nxt = ST_LOW;
                end
            end

            ST_LOW: begin
                if (r_div == DIV_LAST) begin
                    // Sample as late as possible in the low phase
                    w_sample    = 1'b1;
                    w_div_nxt   = '0;
                    w_state_nxt = ST_HIGH;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end

            ST_HIGH: begin
                if (r_div == DIV_LAST) begin
                    w_div_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_bit_nxt = 3'd0;
                        w_idx_nxt = r_idx + 1'b1;
                        if (r_idx == 4'd11) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_tmo_nxt   = '0;
                            w_state_nxt = ST_WAIT;
                        end
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_state_nxt = ST_LOW;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end

            ST_WAIT: begin
                if (w_req && !w_sync) begin
                    w_bit_nxt   = 3'd0;
                    w_div_nxt   = '0;
                    w_state_nxt = ST_LOW;
                end else if (w_req && w_sync) begin
                    // Drive restarted its frame: replay the same TX buffer from byte 0
                    w_frame_err = 1'b1;
                    w_idx_nxt   = 4'd0;
                    w_bit_nxt   = 3'd0;
                    w_div_nxt   = '0;
                    w_state_nxt = ST_LOW;
                end else if (r_tmo == TMO_LAST) begin
                    w_frame_err = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pending command, TX/RX buffers, registered outputs
    // ------------------------------------------------------------------
    logic [95:0] r_pend;
    logic [95:0] r_tx;
    logic [95:0] r_rx;
    logic [95:0] r_stat;
    logic        r_busy;
    logic        r_stat_vld;
    logic        r_csum_err;
    logic        r_frame_err;
    logic        r_active;
    logic        r_comclk;
    logic        r_hdata;
    logic [95:0] w_tx_new;
    logic [95:0] w_tx_src;

    assign w_tx_new = AUTO_CSUM ? {f_csum(r_pend), r_pend[87:0]} : r_pend;
    // On frame start the TX buffer is loaded in the same edge, so the first bit comes from the new value
    assign w_tx_src = w_start ? w_tx_new : r_tx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend      <= IDLE_FRAME;
            r_tx        <= IDLE_FRAME;
            r_rx        <= '0;
            r_stat      <= '0;
            r_busy      <= 1'b0;
            r_stat_vld  <= 1'b0;
            r_csum_err  <= 1'b0;
            r_frame_err <= 1'b0;
            r_active    <= 1'b0;
            r_comclk    <= 1'b1;
            r_hdata     <= 1'b0;
        end else begin
            // A write in the frame-take cycle lands in r_pend for the next frame and keeps busy set
            if (io_host.cmd_wr) begin
                r_pend <= io_host.cmd_dat;
                r_busy <= 1'b1;
            end else if (w_start) begin
                r_busy <= 1'b0;
            end

            if (w_start) begin
                r_tx <= w_tx_new;
            end

            if (w_sample) begin
                r_rx[{r_idx, r_bit}] <= r_cdata_s[1];
            end

            // Serial outputs registered from next state so they change exactly on state entry
            r_comclk <= (w_state_nxt != ST_LOW);
            if (w_state_nxt == ST_LOW) begin
                r_hdata <= w_tx_src[{w_idx_nxt, w_bit_nxt}];
            end

            r_active    <= (w_state_nxt == ST_LOW) || (w_state_nxt == ST_HIGH) ||
                           (w_state_nxt == ST_WAIT);
            r_frame_err <= w_frame_err;
            r_stat_vld  <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                r_stat     <= r_rx;
                r_csum_err <= (r_rx[95:88] != f_csum(r_rx));
            end
        end
    end

    assign io_host.cmd_busy      = r_busy;
    assign io_host.stat_dat      = r_stat;
    assign io_host.stat_vld      = r_stat_vld;
    assign io_host.stat_csum_err = r_csum_err;
    assign io_host.frame_err     = r_frame_err;
    assign io_host.active        = r_active;
    assign o_cd_comclk           = r_comclk;
    assign o_cd_hdata            = r_hdata;

endmodule

// File: tb/tb_cdd_host_link.sv
// Bench for cdd_host_link: behavioural drive model plus scoreboard of expected status/abort events.
// Latency: n/a.
// Backpressure: n/a.
module tb_cdd_host_link;
    localparam int CLK_DIV = 4;
    localparam int TIMEOUT = 300;

    typedef struct {
        bit          is_err;
        logic [95:0] dat;
        bit          cerr;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic comclk;
    logic hdata;
    logic cdata = 1'b0;
    logic comreq_n = 1'b1;
    logic comsync_n = 1'b1;

    int total = 0;
    int bad = 0;

    ev_t exp_q[$];

    // Reference model state: pending command, busy flag, last complete status
    logic [95:0] m_pend = {8'hFF, 88'h0};
    logic        m_busy = 1'b0;
    logic [95:0] m_last = '0;

    always #5 clk = ~clk;

    cdd_host_link_if bus ();

    cdd_host_link #(
        .CLK_DIV   (CLK_DIV),
        .TIMEOUT   (TIMEOUT),
        .AUTO_CSUM (1'b1)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .io_host        (bus),
        .o_cd_comclk    (comclk),
        .o_cd_hdata     (hdata),
        .i_cd_cdata     (cdata),
        .i_cd_comreq_n  (comreq_n),
        .i_cd_comsync_n (comsync_n)
    );

    // Checksum rule in plain arithmetic: 255 - (sum of bytes 0..10 mod 256)
    function automatic logic [7:0] m_chk(input logic [95:0] f);
        int s;
        s = 0;
        for (int i = 0; i < 11; i++) s += int'(f[8*i +: 8]);
        return 8'(255 - (s % 256));
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [95:0] rand_stat(input bit good);
        logic [95:0] s;
        s = {$urandom, $urandom, $urandom};
        if (good) s[95:88] = m_chk(s);
        else      s[95:88] = m_chk(s) ^ 8'($urandom_range(1, 255));
        return s;
    endfunction

    // Frame take: expected TX = pending with byte 11 replaced by checksum; busy clears
    task automatic take(output logic [95:0] e);
        e = m_pend;
        e[95:88] = m_chk(m_pend);
        m_busy = 1'b0;
    endtask

    task automatic push_stat(input logic [95:0] st);
        ev_t e;
        e.is_err = 1'b0;
        e.dat    = st;
        e.cerr   = (st[95:88] != m_chk(st));
        exp_q.push_back(e);
        m_last = st;
    endtask

    task automatic push_err();
        ev_t e;
        e.is_err = 1'b1;
        e.dat    = '0;
        e.cerr   = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic cmd_write(input logic [95:0] d);
        bus.cmd_dat = d;
        bus.cmd_wr  = 1'b1;
        @(negedge clk);
        bus.cmd_wr  = 1'b0;
        m_pend = d;
        m_busy = 1'b1;
    endtask

    task automatic wait_rise(output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = comclk;
        for (int i = 0; i < 40 * CLK_DIV; i++) begin
            @(negedge clk);
            if (!prev && comclk) begin
                ok = 1'b1;
                return;
            end
            prev = comclk;
        end
    endtask

    // Drive side of one byte: request, present status bits, capture host bits at COMCLK rise
    task automatic send_byte(input logic [7:0] sb, input bit sync, output logic [7:0] got, output bit ok);
        bit r;
        got       = 8'h00;
        ok        = 1'b1;
        comsync_n = !sync;
        cdata     = sb[0];
        @(negedge clk);
        comreq_n = 1'b0;
        repeat (3) @(negedge clk);
        comreq_n = 1'b1;
        for (int b = 0; b < 8; b++) begin
            wait_rise(r);
            if (!r) begin
                ok = 1'b0;
                break;
            end
            got[b] = hdata;
            if (b < 7) cdata = sb[b+1];
        end
        comsync_n = 1'b1;
        repeat ($urandom_range(CLK_DIV + 1, CLK_DIV + 8)) @(negedge clk);
    endtask

    task automatic send_range(input logic [95:0] st, input int lo, input int hi,
                              output logic [95:0] tx, output bit ok);
        logic [7:0] g;
        bit r;
        tx = '0;
        ok = 1'b1;
        for (int i = lo; i <= hi; i++) begin
            send_byte(st[8*i +: 8], (i == 0), g, r);
            tx[8*i +: 8] = g;
            if (!r) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic drain(input string nm, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: events outstanding=%0d want 0", nm, exp_q.size());
        end
    endtask

    task automatic run_frame(input string nm, input logic [95:0] st);
        logic [95:0] e;
        logic [95:0] tx;
        bit ok;
        take(e);
        push_stat(st);
        send_range(st, 0, 11, tx, ok);
        chk({nm, "_ok"}, 96'(ok), 96'd1);
        chk({nm, "_tx"}, tx, e);
        drain({nm, "_drain"}, 200);
        chk({nm, "_busy"}, 96'(bus.cmd_busy), 96'(m_busy));
    endtask

    // Scoreboard monitor: every status or abort pulse must match the head of the queue
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bus.stat_vld || bus.frame_err)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: stat_vld=%0b frame_err=%0b want none",
                             bus.stat_vld, bus.frame_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_err", 96'(bus.frame_err), 96'(e.is_err));
                    if (bus.stat_vld && !e.is_err) begin
                        chk("stat_data", bus.stat_dat, e.dat);
                        chk("stat_csum_err", 96'(bus.stat_csum_err), 96'(e.cerr));
                    end
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] st, st2, e, tx, tx0, tx1, cmd_c;
        bit ok, ok1;
        int n;

        bus.cmd_dat = '0;
        bus.cmd_wr  = 1'b0;
        rst         = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_comclk", 96'(comclk), 96'd1);
        chk("rst_hdata", 96'(hdata), 96'd0);
        chk("rst_stat_dat", bus.stat_dat, 96'd0);
        chk("rst_busy", 96'(bus.cmd_busy), 96'd0);
        chk("rst_active", 96'(bus.active), 96'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Idle frame after reset: 00 x11, FF
        run_frame("idle", rand_stat(1'b1));

        // Single command 02 -> checksum FD; busy drops at byte-0 request
        cmd_write({8'h00, 80'h0, 8'h02});
        chk("cmd02_busy_set", 96'(bus.cmd_busy), 96'(m_busy));
        st = 96'hC8_0A_09_08_07_06_05_04_03_02_01_00;
        take(e);
        push_stat(st);
        send_range(st, 0, 0, tx0, ok);
        chk("cmd02_busy_drop", 96'(bus.cmd_busy), 96'(m_busy));
        send_range(st, 1, 11, tx1, ok1);
        chk("cmd02_ok", 96'(ok & ok1), 96'd1);
        tx = tx0 | tx1;
        chk("cmd02_tx", tx, e);
        chk("cmd02_byte11", 96'(tx[95:88]), 96'h0FD);
        drain("cmd02_drain", 200);

        // Same status with a bad checksum byte; command repeats unchanged
        run_frame("csum_bad", 96'hC9_0A_09_08_07_06_05_04_03_02_01_00);

        // Drive stops after byte 5 -> timeout abort, status unchanged
        take(e);
        push_err();
        st = rand_stat(1'b1);
        send_range(st, 0, 5, tx, ok);
        chk("tmo_ok", 96'(ok), 96'd1);
        chk("tmo_tx_part", 96'(tx[47:0]), 96'(e[47:0]));
        chk("tmo_active_wait", 96'(bus.active), 96'd1);
        drain("tmo_drain", TIMEOUT + 200);
        chk("tmo_active", 96'(bus.active), 96'd0);
        chk("tmo_stat_kept", bus.stat_dat, m_last);

        // Resync at byte 7: abort then a full frame replaying the same TX buffer
        cmd_write({$urandom, $urandom, $urandom});
        take(e);
        st  = rand_stat(1'b1);
        st2 = rand_stat(1'b0);
        push_err();
        push_stat(st2);
        send_range(st, 0, 6, tx0, ok);
        send_range(st2, 0, 11, tx, ok1);
        chk("resync_ok", 96'(ok & ok1), 96'd1);
        chk("resync_tx_part", 96'(tx0[55:0]), 96'(e[55:0]));
        chk("resync_tx", tx, e);
        drain("resync_drain", 200);

        // A then B before the frame -> B; C during the frame -> next frame
        cmd_write({$urandom, $urandom, $urandom});
        cmd_write({$urandom, $urandom, $urandom});
        cmd_c = {$urandom, $urandom, $urandom};
        take(e);
        st = rand_stat(1'b1);
        push_stat(st);
        fork
            send_range(st, 0, 11, tx, ok);
            begin
                repeat (300) @(negedge clk);
                cmd_write(cmd_c);
            end
        join
        chk("ab_ok", 96'(ok), 96'd1);
        chk("ab_tx_is_b", tx, e);
        drain("ab_drain", 200);
        chk("c_busy_held", 96'(bus.cmd_busy), 96'(m_busy));
        run_frame("c_frame", rand_stat(1'b0));

        // Reset while in the low phase of byte 3
        cmd_write({$urandom, $urandom, $urandom});
        take(e);
        st = rand_stat(1'b1);
        send_range(st, 0, 2, tx, ok);
        chk("rstmid_ok", 96'(ok), 96'd1);
        comsync_n = 1'b1;
        cdata     = st[24];
        @(negedge clk);
        comreq_n = 1'b0;
        n = 0;
        while (comclk !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_in_low", 96'(comclk), 96'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_comclk", 96'(comclk), 96'd1);
        chk("rstmid_no_stat", 96'(bus.stat_vld), 96'd0);
        chk("rstmid_no_err", 96'(bus.frame_err), 96'd0);
        comreq_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_pend = {8'hFF, 88'h0};
        m_busy = 1'b0;
        m_last = '0;
        repeat (3) @(negedge clk);
        chk("rstmid_stat_dat", bus.stat_dat, 96'd0);
        chk("rstmid_active", 96'(bus.active), 96'd0);
        chk("rstmid_busy", 96'(bus.cmd_busy), 96'd0);
        run_frame("post_rst_idle", rand_stat(1'b1));

        // Randomised frames
        for (int k = 0; k < 5; k++) begin
            if ($urandom_range(0, 1) == 1) cmd_write({$urandom, $urandom, $urandom});
            run_frame("rand", rand_stat(1'($urandom_range(0, 1))));
        end

        drain("final_drain", 100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
